obi_sram_adapter: RTL

//  Upstream stage of the single-port SRAM macro. Converts one byte-addressed OBI subordinate port

---
 rtl/obi_sram_adapter_pkg.sv | 17 +
 rtl/obi_sram_adapter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/obi_sram_adapter_pkg.sv
// rtl/obi_sram_adapter_pkg.sv - shared state type and word-decode helper for obi_sram_adapter
package obi_sram_adapter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RSP  = 2'd2
   } state_e;

   localparam int unsigned DEFAULT_DATA_WIDTH = 32;
   localparam int unsigned OFF_BITS           = $clog2(DEFAULT_DATA_WIDTH / 8);

   function automatic logic [31:0] word_index(input logic [31:0] off, input int unsigned off_bits);
      return off >> off_bits;
   endfunction

endpackage

// File: rtl/obi_sram_adapter.sv
// rtl/obi_sram_adapter.sv - OBI subordinate to single-port SRAM req/gnt/rvalid adapter, one outstanding
// Optional handshake parity checking is enabled by defining OBI_SRAM_ADAPTER_PARCHK_EN.
module obi_sram_adapter
   import obi_sram_adapter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned NUM_WORDS  = 1024,
   parameter logic [31:0] BASE_ADDR  = 32'h0
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          obi_req_i,
   output logic                          obi_gnt_o,
   input  logic [31:0]                   obi_addr_i,
   input  logic                          obi_we_i,
   input  logic [DATA_WIDTH/8-1:0]       obi_be_i,
   input  logic [DATA_WIDTH-1:0]         obi_wdata_i,
   output logic                          obi_rvalid_o,
   input  logic                          obi_rready_i,
   output logic [DATA_WIDTH-1:0]         obi_rdata_o,
   output logic                          obi_err_o,
   output logic                          sram_req_o,
   output logic                          sram_we_o,
   output logic [$clog2(NUM_WORDS)-1:0]  sram_addr_o,
   output logic [DATA_WIDTH-1:0]         sram_wdata_o,
   output logic [DATA_WIDTH/8-1:0]       sram_be_o,
   output logic                          sram_rready_o,
   input  logic                          sram_gnt_i,
   input  logic                          sram_gntpar_i,
   input  logic                          sram_rvalid_i,
   input  logic                          sram_rvalidpar_i,
   input  logic [DATA_WIDTH-1:0]         sram_rdata_i,
   output logic                          fault_o
);

   localparam int unsigned AW            = $clog2(NUM_WORDS);
   localparam int unsigned WORD_OFF_BITS = $clog2(DATA_WIDTH / 8);
   localparam logic [31:0] LOW_MASK      = (32'd1 << WORD_OFF_BITS) - 32'd1;

   state_e                  state_q, state_d;
   logic [31:0]             off, word;
   logic                    bad, take, fault_now;
   logic                    we_q, err_pend_q, fault_q;
   logic                    rsp_err_q;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q;

   assign off  = obi_addr_i - BASE_ADDR;
   assign word = word_index(off, WORD_OFF_BITS);
   assign bad  = (obi_addr_i < BASE_ADDR) | (word >= 32'(NUM_WORDS)) | ((off & LOW_MASK) != 32'h0);
   // Errors are granted without the SRAM, good requests need the SRAM grant in the same cycle.
   assign take = obi_req_i & (bad | sram_gnt_i);

`ifdef OBI_SRAM_ADAPTER_PARCHK_EN
   assign fault_now = ~(sram_gnt_i ^ sram_gntpar_i) | ~(sram_rvalid_i ^ sram_rvalidpar_i);
`else
   logic unused_par;
   assign unused_par = sram_gntpar_i ^ sram_rvalidpar_i;
   assign fault_now  = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (take) state_d = bad ? RSP : WAIT;
         WAIT:    if (sram_rvalid_i) state_d = RSP;
         RSP:     if (obi_rready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // sram_rready_o stays high in IDLE so a stale response left over from a reset is drained.
   always_comb begin
      obi_gnt_o     = 1'b0;
      sram_req_o    = 1'b0;
      sram_rready_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            obi_gnt_o     = bad | sram_gnt_i;
            sram_req_o    = obi_req_i & ~bad & sram_gnt_i;
            sram_rready_o = 1'b1;
         end
         WAIT:    sram_rready_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         we_q        <= 1'b0;
         err_pend_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else if (state_q == IDLE && take) begin
         we_q       <= obi_we_i;
         err_pend_q <= fault_now;
         if (bad) begin
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
         end
      end else if (state_q == WAIT) begin
         if (sram_rvalid_i) begin
            rsp_err_q   <= err_pend_q | fault_now;
            rsp_rdata_q <= (we_q | err_pend_q | fault_now) ? '0 : sram_rdata_i;
         end else begin
            err_pend_q <= err_pend_q | fault_now;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fault_q <= 1'b0;
      end else if (fault_now) begin
         fault_q <= 1'b1;
      end
   end

   assign obi_rvalid_o = (state_q == RSP);
   assign obi_rdata_o  = rsp_rdata_q;
   assign obi_err_o    = rsp_err_q;
   assign fault_o      = fault_q;

   assign sram_we_o    = obi_we_i;
   assign sram_addr_o  = word[AW-1:0];
   assign sram_wdata_o = obi_wdata_i;
   assign sram_be_o    = obi_be_i;

endmodule
